// File: rtl/alu_op_sequencer.sv
// Initiator side of the ALU result-select interface: accepts one opcode/operand
// request, drives the ALU, captures the result and flags, and hands it on.
// Optional completed-operation counter enabled by defining ALU_SEQ_COUNT_EN.
module alu_op_sequencer #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [2:0]   alu_sel,
  input  logic [N-1:0] alu_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_zero,
  output logic         out_neg,
  output logic         out_err,
  output logic [15:0]  op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e       state_q, state_d;
  logic         in_ready_q, in_ready_d;
  logic [N-1:0] alu_a_q, alu_a_d;
  logic [N-1:0] alu_b_q, alu_b_d;
  logic [2:0]   alu_sel_q, alu_sel_d;
  logic         out_valid_q, out_valid_d;
  logic [N-1:0] out_result_q, out_result_d;
  logic         out_zero_q, out_zero_d;
  logic         out_neg_q, out_neg_d;
  logic         out_err_q, out_err_d;
  logic         out_hs;

  // DONE always has out_valid set, so out_ready alone completes the handshake.
  assign out_hs = (state_q == DONE) && out_ready;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_zero_d   = out_zero_q;
    out_neg_d    = out_neg_q;
    out_err_d    = out_err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          if (in_op == 3'd7) begin
            out_result_d = '0;
            out_zero_d   = 1'b1;
            out_neg_d    = 1'b0;
            out_err_d    = 1'b1;
            out_valid_d  = 1'b1;
            state_d      = DONE;
          end else begin
            alu_a_d   = in_a;
            alu_b_d   = in_b;
            alu_sel_d = in_op;
            state_d   = EXEC;
          end
        end
      end
      EXEC: begin
        out_result_d = alu_result;
        out_zero_d   = (alu_result == '0);
        out_neg_d    = alu_result[N-1];
        out_err_d    = 1'b0;
        out_valid_d  = 1'b1;
        state_d      = DONE;
      end
      DONE: begin
        if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: in_ready is a registered decode of the next state, so it reads 0 while reset is held.
  assign in_ready_d = (state_d == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      in_ready_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_zero_q   <= 1'b0;
      out_neg_q    <= 1'b0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_zero_q   <= out_zero_d;
      out_neg_q    <= out_neg_d;
      out_err_q    <= out_err_d;
    end
  end

`ifdef ALU_SEQ_COUNT_EN
  logic [15:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if (out_hs) op_count_d = op_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) op_count_q <= '0;
    else       op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

  assign in_ready   = in_ready_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_sel    = alu_sel_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_zero   = out_zero_q;
  assign out_neg    = out_neg_q;
  assign out_err    = out_err_q;

endmodule
